// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter built on a single shift-by-two stage.
// One request at a time through a start/busy/done handshake.
module shift_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  input  logic        dir_i,
  input  logic        arith_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  rem;
  logic        dir;
  logic        arith;

  logic        step2;
  logic        fill;
  logic [31:0] work_nxt;
  logic [4:0]  rem_nxt;

  always_comb begin
    step2    = rem >= 5'd2;
    fill     = arith & work[31];
    work_nxt = work;
    rem_nxt  = step2 ? rem - 5'd2 : rem - 5'd1;
    unique case (1'b1)
      !dir &&  step2: work_nxt = {work[29:0], 2'b00};
      !dir && !step2: work_nxt = {work[30:0], 1'b0};
      dir  &&  step2: work_nxt = {{2{fill}}, work[31:2]};
      dir  && !step2: work_nxt = {fill, work[31:1]};
      default:        work_nxt = work;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      dir   <= 1'b0;
      arith <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            work  <= data_i;
            rem   <= shamt_i;
            dir   <= dir_i;
            arith <= arith_i & dir_i;
            state <= (shamt_i == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          rem  <= rem_nxt;
          if (rem_nxt == 5'd0)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign data_o = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer.
// Hand-computed results, latencies and handshake timing.
module tb_shift_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        dir_i = 1'b0;
  logic        arith_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  int n_pass = 0;
  int n_total = 0;

  shift_sequencer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .dir_i   (dir_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] d,
                        input logic [4:0] n,
                        input logic dr,
                        input logic ar,
                        input logic [31:0] exp_d,
                        input int exp_lat);
    int lat;
    int bc;
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = n;
    dir_i   = dr;
    arith_i = ar;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done_o && lat < 40) begin
      if (busy_o) bc++;
      @(posedge clk_i);
      #1 lat++;
    end
    if (busy_o) bc++;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, data_o, exp_d);
    check({tag, " busy cycles"}, bc, exp_lat);
    @(posedge clk_i);
    #1;
    check({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, " busy fall"}, {31'd0, busy_o}, 32'd0);
    check({tag, " hold"}, data_o, exp_d);
  endtask

  initial begin
    int lat;
    int ndone;
    int prev;
    int cyc;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset data", data_o, 32'h0000_0000);
    rst_i = 1'b1;

    run_op("sll2", 32'h0000_0001, 5'd2, 1'b0, 1'b0, 32'h0000_0004, 2);
    run_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
    run_op("sll5", 32'h0000_0003, 5'd5, 1'b0, 1'b0, 32'h0000_0060, 4);
    run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 17);
    run_op("srl31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 17);
    run_op("srl3", 32'h0000_00F0, 5'd3, 1'b1, 1'b0, 32'h0000_001E, 3);
    run_op("sra16", 32'h7FFF_0000, 5'd16, 1'b1, 1'b1, 32'h0000_7FFF, 9);
    run_op("sll_ar", 32'h8000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0002, 2);

    // start pulses during SHIFT and DONE must be dropped
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'h0000_00FF;
    shamt_i = 5'd8;
    dir_i   = 1'b0;
    arith_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'h1234_5678;
    shamt_i = 5'd0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    lat = 2;
    while (!done_o && lat < 40) begin
      @(posedge clk_i);
      #1 lat++;
    end
    check("ign latency", lat, 5);
    check("ign data", data_o, 32'h0000_FF00);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    check("ign done busy", {31'd0, busy_o}, 32'd0);
    check("ign done data", data_o, 32'h0000_FF00);
    @(posedge clk_i);
    #1;
    check("ign idle busy", {31'd0, busy_o}, 32'd0);
    check("ign idle data", data_o, 32'h0000_FF00);

    // reset in the middle of a long shift
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'hA5A5_A5A5;
    shamt_i = 5'd31;
    dir_i   = 1'b1;
    arith_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("mid busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst data", data_o, 32'h0000_0000);
    rst_i = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk_i);
      #1;
      if (done_o) ndone++;
    end
    check("rst no done", ndone, 0);

    // start held high: one result every ceil(4/2)+2 cycles
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'hF000_000F;
    shamt_i = 5'd4;
    dir_i   = 1'b1;
    arith_i = 1'b1;
    ndone = 0;
    prev  = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i);
      #1;
      cyc = c;
      if (done_o) begin
        ndone++;
        check("b2b data", data_o, 32'hFF00_0000);
        if (prev >= 0)
          check("b2b period", cyc - prev, 4);
        prev = cyc;
      end
    end
    check("b2b count", ndone, 5);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    check("b2b idle", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
